dot_collector: RTL and testbench
================================

DOT_COLLECTOR -- requirements
Module: dot_collector

Interface
REQ-001 Parameter: DOT_POINTS, 10, score added per dot eaten.
REQ-002 Parameter: PELLET_POINTS, 50, score added per power pellet eaten (POWER_PELLET_EN only).
REQ-003 Parameter: FRIGHT_CYCLES, 25_000_000, frightened-window length in clk cycles (POWER_PELLET_EN only).
REQ-004 Parameter: SCORE_W, 16, score width.
REQ-005 Port: clk  input  1  single system clock; all state updates on posedge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: move_strobe  input  1  one-cycle pulse; x/y hold a new player position.
REQ-008 Port: x  input  $clog2(`WIDTH)  player pixel x (next_x from player control).
REQ-009 Port: y  input  $clog2(`HEIGHT)  player pixel y.
REQ-010 Port: level_restart  input  1  reload maps; keep score.
REQ-011 Port: init_dots  input  `tile_row_num*`tile_col_num  initial dot map, sampled on reset/restart.
REQ-012 Port: init_pellets  input  same width  initial pellet map (POWER_PELLET_EN only).
REQ-013 Port: tilemap_dots  output  same width  live dot map, 1 = dot present.
REQ-014 Port: score  output  SCORE_W  accumulated score.
REQ-015 Port: dots_remaining  output  $clog2(map bits)+1  uneaten dots (+pellets).
REQ-016 Port: dot_eaten  output  1  one-cycle pulse per item consumed.
REQ-017 Port: level_clear  output  1  sticky flag, all items eaten.
REQ-018 Port: frightened  output  1  power-pellet window active (POWER_PELLET_EN only).

Function
REQ-019 Stage 1 (cycle N+1 after strobe at N): register tile_idx = `tile_col_num*(y/`tile_size) + x/`tile_size, plus valid bit.
REQ-020 Stage 2 (cycle N+2): if map bit set, clear it, add points, pulse dot_eaten, decrement dots_remaining; latency exactly 2 cycles.
REQ-021 Back-to-back strobes fully pipelined, one per cycle, none dropped.
REQ-022 Two consecutive strobes to same tile: count once (stage-2 clear forwarded to next lookup).
REQ-023 Strobe with x>=`WIDTH or y>=`HEIGHT: ignored, no state change.
REQ-024 Score saturates at 2^SCORE_W-1; no wrap.
REQ-025 level_clear sets in same cycle dots_remaining becomes 0; holds until reset/level_restart; strobes after clear change nothing.
REQ-026 level_restart: next cycle tilemap_dots=init_dots, dots_remaining=popcount of map(s), level_clear=0, pipeline flushed, score unchanged.
REQ-027 level_restart coincident with strobe or stage-2 hit: restart wins, in-flight item discarded.
REQ-028 No strobe: all outputs hold; dot_eaten low.

Reset
REQ-029 On reset: score=0, tilemap_dots=init_dots, dots_remaining=popcount, dot_eaten=0, level_clear=0 (1 if popcount=0), frightened=0, pipeline valid=0.
REQ-030 Reset asserted mid-operation discards in-flight lookups; overrides level_restart.

Configuration
REQ-031 Macro POWER_PELLET_EN defined: pellet map kept, pellet hit adds PELLET_POINTS, loads fright counter to FRIGHT_CYCLES, frightened high until expiry; re-eat reloads counter; pellets count in dots_remaining; dot and pellet in one tile count as one item scoring PELLET_POINTS.
REQ-032 POWER_PELLET_EN undefined: init_pellets, frightened, counter and pellet map absent; dots only.

Structure
REQ-033 `tile_size, `tile_row_num, `tile_col_num, `WIDTH, `HEIGHT come from shared define.v; no local copies.
REQ-034 Sub-module tile_indexer: pixel x/y -> tile_idx plus out-of-bounds flag, combinational, reused by ghost logic.

Verification
REQ-035 Dot at idx 34, strobe x=40,y=20 -> cycle N+2 dot_eaten=1, score 0->10, bit 34 cleared, dots_remaining-1.
REQ-036 Strobes x=40,y=20 on consecutive cycles -> one dot_eaten pulse, score=10.
REQ-037 score=65530, eat dot -> score=65535; eat again -> 65535.
REQ-038 Single-dot map, eat it -> level_clear=1 at N+2; level_restart -> map reloaded, level_clear=0, score kept.
REQ-039 POWER_PELLET_EN, FRIGHT_CYCLES=8: pellet eaten -> score +50, frightened high 8 cycles; re-eat at cycle 4 -> window extends to 8 from re-eat.
REQ-040 Strobe x=700,y=20 -> no change; reset coincident with stage-2 hit -> score=0, no dot_eaten.

Source files
------------

// File: rtl/dot_collector_pkg.sv
// Shared types and geometry-derived widths for the dot collector and its tile indexer.
`include "define.v"

package dot_collector_pkg;

    localparam int unsigned WIDTH_PX   = `WIDTH;
    localparam int unsigned HEIGHT_PX  = `HEIGHT;
    localparam int unsigned TILE_SIZE  = `TILE_SIZE;
    localparam int unsigned TILE_COLS  = `TILE_COL_NUM;
    localparam int unsigned TILE_ROWS  = `TILE_ROW_NUM;
    localparam int unsigned MAP_BITS   = TILE_COLS * TILE_ROWS;
    localparam int unsigned X_W        = $clog2(`WIDTH);
    localparam int unsigned Y_W        = $clog2(`HEIGHT);
    localparam int unsigned IDX_W      = $clog2(MAP_BITS);
    localparam int unsigned CNT_W      = $clog2(MAP_BITS) + 1;

    typedef logic [MAP_BITS-1:0] map_t;

    // What the stage-2 lookup found in the addressed tile.
    typedef enum logic [1:0] {
        ITEM_NONE,
        ITEM_DOT,
        ITEM_PELLET
    } item_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } lookup_t;

    function automatic logic [CNT_W-1:0] popcount(input map_t m);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAP_BITS; i++) begin
            n = n + CNT_W'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dot_collector_if.sv
// Player-move / map-state bus between the game core and the dot collector.
// POWER_PELLET_EN adds the pellet map input and the frightened output.
interface dot_collector_if #(
    parameter int unsigned SCORE_W = 16
);
    import dot_collector_pkg::*;

    logic                 move_strobe;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic                 level_restart;
    map_t                 init_dots;
    map_t                 tilemap_dots;
    logic [SCORE_W-1:0]   score;
    logic [CNT_W-1:0]     dots_remaining;
    logic                 dot_eaten;
    logic                 level_clear;
`ifdef POWER_PELLET_EN
    map_t                 init_pellets;
    logic                 frightened;

    modport master (
        output move_strobe, x, y, level_restart, init_dots, init_pellets,
        input  tilemap_dots, score, dots_remaining, dot_eaten, level_clear, frightened
    );
    modport slave (
        input  move_strobe, x, y, level_restart, init_dots, init_pellets,
        output tilemap_dots, score, dots_remaining, dot_eaten, level_clear, frightened
    );
`else
    modport master (
        output move_strobe, x, y, level_restart, init_dots,
        input  tilemap_dots, score, dots_remaining, dot_eaten, level_clear
    );
    modport slave (
        input  move_strobe, x, y, level_restart, init_dots,
        output tilemap_dots, score, dots_remaining, dot_eaten, level_clear
    );
`endif
endinterface

// File: rtl/define.v
// Shared maze geometry: screen size in pixels and the tile grid laid over it.
`ifndef DEFINE_V
`define DEFINE_V
`define WIDTH        640
`define HEIGHT       480
`define TILE_SIZE    20
`define TILE_COL_NUM 32
`define TILE_ROW_NUM 24
`endif

// File: rtl/dot_collector_tile_indexer.sv
// tile_indexer: pixel coordinate -> tile map index plus out-of-bounds flag.
// Purely combinational so ghost logic can share it.
module tile_indexer
    import dot_collector_pkg::*;
(
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    output logic [IDX_W-1:0] o_tile_idx,
    output logic             o_oob
);

    logic [X_W-1:0] w_col;
    logic [Y_W-1:0] w_row;

    assign w_col = i_x / X_W'(TILE_SIZE);
    assign w_row = i_y / Y_W'(TILE_SIZE);

    // Index is only meaningful when o_oob is low.
    assign o_tile_idx = IDX_W'(w_row) * IDX_W'(TILE_COLS) + IDX_W'(w_col);
    assign o_oob      = (32'(i_x) >= WIDTH_PX) || (32'(i_y) >= HEIGHT_PX);

endmodule

// File: rtl/dot_collector.sv
// Two-stage dot/pellet collector: stage 1 registers the tile index, stage 2 consumes the item.
// Optional feature macro: POWER_PELLET_EN (pellet map, pellet scoring, frightened window).
module dot_collector
    import dot_collector_pkg::*;
#(
    parameter int unsigned DOT_POINTS    = 10,
    parameter int unsigned PELLET_POINTS = 50,
    parameter int unsigned FRIGHT_CYCLES = 25_000_000,
    parameter int unsigned SCORE_W       = 16
) (
    input logic            clk,
    input logic            reset,
    dot_collector_if.slave bus
);

    logic [IDX_W-1:0]   w_tile_idx;
    logic               w_oob;
    map_t               w_init_items;
    logic [CNT_W-1:0]   w_init_count;
    item_e              w_item;
    logic [SCORE_W-1:0] w_points;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_score_next;

    lookup_t            r_lookup;
    map_t               r_dots;
    logic [SCORE_W-1:0] r_score;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_dot_eaten;
    logic               r_level_clear;

`ifdef POWER_PELLET_EN
    localparam int unsigned FRIGHT_W = $clog2(FRIGHT_CYCLES + 1);
    map_t                r_pellets;
    logic [FRIGHT_W-1:0] r_fright;

    assign w_init_items = bus.init_dots | bus.init_pellets;
`else
    assign w_init_items = bus.init_dots;
`endif

    assign w_init_count = popcount(w_init_items);

    tile_indexer u_tile_indexer (
        .i_x        (bus.x),
        .i_y        (bus.y),
        .o_tile_idx (w_tile_idx),
        .o_oob      (w_oob)
    );

    // Stage 1: capture the tile index of an in-bounds move.
    always_ff @(posedge clk) begin
        if (reset || bus.level_restart) begin
            r_lookup <= '0;
        end else begin
            r_lookup.valid <= bus.move_strobe && !w_oob;
            r_lookup.idx   <= w_tile_idx;
        end
    end

    // Stage 2 lookup reads the registered map, so a clear from the previous
    // cycle is already visible to a repeated strobe on the same tile.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_item = ITEM_NONE;
        if (r_lookup.valid) begin
`ifdef POWER_PELLET_EN
            if (r_pellets[r_lookup.idx]) w_item = ITEM_PELLET;
            else
`endif
            if (r_dots[r_lookup.idx]) w_item = ITEM_DOT;
        end
    end

    assign w_points     = (w_item == ITEM_PELLET) ? SCORE_W'(PELLET_POINTS) : SCORE_W'(DOT_POINTS);
    assign w_sum        = {1'b0, r_score} + {1'b0, w_points};
    assign w_score_next = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

    // NOTE: the maps are flop arrays, not RAM, so reset can reload them in one cycle.
    always_ff @(posedge clk) begin
        if (reset || bus.level_restart) begin
            r_dots        <= bus.init_dots;
`ifdef POWER_PELLET_EN
            r_pellets     <= bus.init_pellets;
`endif
            r_remaining   <= w_init_count;
            r_level_clear <= (w_init_count == '0);
            r_dot_eaten   <= 1'b0;
            if (reset) r_score <= '0;
        end else begin
            r_dot_eaten <= (w_item != ITEM_NONE);
            if (w_item != ITEM_NONE) begin
                r_dots[r_lookup.idx]    <= 1'b0;
`ifdef POWER_PELLET_EN
                r_pellets[r_lookup.idx] <= 1'b0;
`endif
                r_score     <= w_score_next;
                r_remaining <= r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) r_level_clear <= 1'b1;
            end
        end
    end

`ifdef POWER_PELLET_EN
    // A new pellet always restarts the full window, even mid-window.
    always_ff @(posedge clk) begin
        if (reset || bus.level_restart) begin
            r_fright <= '0;
        end else if (w_item == ITEM_PELLET) begin
            r_fright <= FRIGHT_W'(FRIGHT_CYCLES);
        end else if (r_fright != '0) begin
            r_fright <= r_fright - FRIGHT_W'(1);
        end
    end

    assign bus.frightened = (r_fright != '0);
`endif

    assign bus.tilemap_dots   = r_dots;
    assign bus.score          = r_score;
    assign bus.dots_remaining = r_remaining;
    assign bus.dot_eaten      = r_dot_eaten;
    assign bus.level_clear    = r_level_clear;

endmodule

// File: tb/tb_dot_collector.sv
// Bench for dot_collector: directed steps plus random moves against a tile-level scoreboard.
// Exercises pellet behaviour only when POWER_PELLET_EN is defined.
`ifndef TILE_SIZE
`include "define.v"
`endif

module tb_dot_collector;

    localparam int TS    = `TILE_SIZE;
    localparam int COLS  = `TILE_COL_NUM;
    localparam int ROWS  = `TILE_ROW_NUM;
    localparam int W     = `WIDTH;
    localparam int H     = `HEIGHT;
    localparam int NB    = COLS * ROWS;
    localparam int XW    = $clog2(`WIDTH);
    localparam int YW    = $clog2(`HEIGHT);
    localparam int DOTP  = 10;
    localparam int PELP  = 50;
    localparam int FC    = 8;
    localparam int SW    = 16;
    localparam int SMAX  = (1 << SW) - 1;

    typedef struct {
        int due;
        int idx;
    } pend_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    dot_collector_if #(.SCORE_W(SW)) bus ();

    dot_collector #(
        .DOT_POINTS    (DOTP),
        .PELLET_POINTS (PELP),
        .FRIGHT_CYCLES (FC),
        .SCORE_W       (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // Scoreboard state: what the player should see after each clock edge.
    bit [NB-1:0] m_dots, m_pel;
    int          m_score, m_rem, m_fright, cyc;
    bit          m_eaten, m_clear;
    pend_t       q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcnt(input bit [NB-1:0] m);
        int n = 0;
        for (int i = 0; i < NB; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic bit [NB-1:0] rand_map(input int one_in);
        bit [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = ($urandom_range(0, one_in - 1) == 0);
        return m;
    endfunction

    task automatic reload();
        m_dots = bus.init_dots;
`ifdef POWER_PELLET_EN
        m_pel  = bus.init_pellets;
`else
        m_pel  = '0;
`endif
        m_rem    = popcnt(m_dots | m_pel);
        m_clear  = (m_rem == 0);
        m_eaten  = 1'b0;
        m_fright = 0;
        q.delete();
    endtask

    task automatic consume(input int i);
        if (m_dots[i] || m_pel[i]) begin
            m_score = m_score + (m_pel[i] ? PELP : DOTP);
            if (m_score > SMAX) m_score = SMAX;
            if (m_pel[i]) m_fright = FC;
            m_dots[i] = 1'b0;
            m_pel[i]  = 1'b0;
            m_rem--;
            if (m_rem == 0) m_clear = 1'b1;
            m_eaten = 1'b1;
        end
    endtask

    task automatic step(input bit s, input int xx, input int yy, input bit rs, input bit rr);
        pend_t p;
        bus.move_strobe   = s;
        bus.x             = XW'(xx);
        bus.y             = YW'(yy);
        bus.level_restart = rr;
        reset             = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            reload();
            m_score = 0;
        end else if (rr) begin
            reload();
        end else begin
            m_eaten = 1'b0;
            if (m_fright > 0) m_fright--;
            if (q.size() > 0 && q[0].due == cyc) begin
                p = q.pop_front();
                consume(p.idx);
            end
            if (s && xx < W && yy < H) q.push_back('{cyc + 1, (yy / TS) * COLS + xx / TS});
        end
        #1;
        check("dot_eaten",      NB'(bus.dot_eaten),      NB'(m_eaten));
        check("score",          NB'(bus.score),          NB'(m_score));
        check("dots_remaining", NB'(bus.dots_remaining), NB'(m_rem));
        check("level_clear",    NB'(bus.level_clear),    NB'(m_clear));
        check("tilemap_dots",   bus.tilemap_dots,        m_dots);
`ifdef POWER_PELLET_EN
        check("frightened",     NB'(bus.frightened),     NB'(m_fright > 0));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit [NB-1:0] m;
        int px, py, r;

        cyc = 0;
        bus.move_strobe   = 1'b0;
        bus.x             = '0;
        bus.y             = '0;
        bus.level_restart = 1'b0;
        m = rand_map(2);
        m[34] = 1'b1;
        bus.init_dots = m;
`ifdef POWER_PELLET_EN
        bus.init_pellets = '0;
`endif

        // Reset state, then a single eat of tile 34 at (40,20).
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(2);
        step(1, 40, 20, 0, 0);
        idle(3);

        // Back-to-back strobes on the same tile count once.
        step(0, 0, 0, 0, 1);
        step(1, 40, 20, 0, 0);
        step(1, 40, 20, 0, 0);
        idle(3);

        // Out-of-bounds strobes are ignored; last in-bounds pixel hits tile NB-1.
        step(1, 700, 20, 0, 0);
        step(1, 40, 500, 0, 0);
        step(1, W - 1, H - 1, 0, 0);
        idle(3);

        // Restart coincident with a stage-2 hit, then with a strobe.
        step(0, 0, 0, 0, 1);
        step(1, 40, 20, 0, 0);
        step(0, 0, 0, 0, 1);
        idle(3);
        step(1, 40, 20, 0, 1);
        idle(3);

        // Reset coincident with a stage-2 hit, and reset overriding restart.
        step(1, 60, 20, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 40, 20, 0, 0);
        step(0, 0, 0, 1, 1);
        idle(3);

        // Single-dot map: clear, post-clear strobes, restart keeps score.
        step(1, 40, 20, 0, 0);
        idle(3);
        m = '0;
        m[34] = 1'b1;
        bus.init_dots = m;
        step(0, 0, 0, 0, 1);
        step(1, 40, 20, 0, 0);
        idle(3);
        step(1, 40, 20, 0, 0);
        step(1, 100, 100, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1);
        idle(2);

`ifdef POWER_PELLET_EN
        // Pellets: window length, re-eat extension, dot+pellet sharing a tile.
        m = '0;
        m[36] = 1'b1;
        m[37] = 1'b1;
        bus.init_dots = m;
        m = '0;
        m[34] = 1'b1;
        m[35] = 1'b1;
        m[36] = 1'b1;
        bus.init_pellets = m;
        step(0, 0, 0, 0, 1);
        step(1, 40, 20, 0, 0);
        idle(4);
        step(1, 60, 20, 0, 0);
        idle(12);
        step(1, 80, 20, 0, 0);
        step(1, 100, 20, 0, 0);
        idle(12);
        bus.init_pellets = '0;
`endif

        // Full-map sweeps from zero score until the score saturates.
        bus.init_dots = '1;
        step(0, 0, 0, 1, 0);
        for (int pass = 0; pass < 9; pass++) begin
            for (int row = 0; row < ROWS; row++) begin
                for (int col = 0; col < COLS; col++) begin
                    step(1, col * TS + $urandom_range(0, TS - 1), row * TS + $urandom_range(0, TS - 1), 0, 0);
                end
            end
            idle(2);
            step(1, 40, 20, 0, 0);
            idle(2);
            step(0, 0, 0, 0, 1);
        end

        // Random moves, repeats, restarts and resets over random maps.
        px = 40;
        py = 20;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r < 4) begin
                bus.init_dots = rand_map(3);
`ifdef POWER_PELLET_EN
                bus.init_pellets = rand_map(16);
`endif
                step(0, 0, 0, (r == 0), 1);
            end else begin
                if ($urandom_range(0, 4) != 0) begin
                    px = $urandom_range(0, W + 60);
                    py = $urandom_range(0, H + 20);
                end
                step(($urandom_range(0, 9) < 7), px, py, 0, 0);
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
